// File: rtl/aes_round_ctrl.sv
// ============================================================================
// aes_round_ctrl
// ----------------------------------------------------------------------------
// Iterative AES-128 encryption sequencer. It steers the shared round datapath
// (SubBytes, registered ShiftRows, MixColumns, AddRoundKey) and the key
// expansion unit. It accepts one block through a valid/ready handshake, walks
// the datapath through the initial AddRoundKey plus NUM_ROUNDS rounds, and
// then holds the ciphertext until the consumer takes it.
//
// Parameters:
//   NUM_ROUNDS   - full rounds after the initial AddRoundKey (2..15, AES-128 = 10)
//   ROUND_CYCLES - clock cycles the datapath needs per round (1..4)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous, active-high reset
//   in_valid   in   plaintext and key present on the datapath inputs
//   in_ready   out  controller can accept a block (forced low while rst is high)
//   out_valid  out  datapath state register holds the ciphertext
//   out_ready  in   consumer accepts the ciphertext
//   abort      in   (only with AES_ROUND_ABORT_EN) drop the block in flight
//   load_in    out  datapath loads plaintext ^ key, key unit loads cipher key
//   state_ld   out  datapath state register captures the round result
//   key_step   out  key unit advances to the next round key using rcon
//   mix_en     out  MixColumns is part of the current round (0 in the last)
//   round_idx  out  current round number, 0..NUM_ROUNDS
//   rcon       out  round constant for the current round
//   busy       out  a block is in flight (state ROUND)
//
// Optional feature:
//   Define AES_ROUND_ABORT_EN to add the abort input. Without the macro only
//   rst can terminate a block.
// ============================================================================
module aes_round_ctrl #(
    parameter int NUM_ROUNDS   = 10,
    parameter int ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       out_valid,
    input  logic       out_ready,
`ifdef AES_ROUND_ABORT_EN
    input  logic       abort,
`endif
    output logic       load_in,
    output logic       state_ld,
    output logic       key_step,
    output logic       mix_en,
    output logic [3:0] round_idx,
    output logic [7:0] rcon,
    output logic       busy
);

    // Index of the final round and of the final cycle inside a round, sized
    // to match the registers they are compared against.
    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);
    localparam logic [1:0] LAST_CYCLE = 2'(ROUND_CYCLES - 1);
    localparam logic [7:0] RCON_INIT  = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_DONE
    } state_t;

    state_t     state_q,     state_d;
    logic [3:0] round_idx_q, round_idx_d;
    logic [7:0] rcon_q,      rcon_d;
    logic [1:0] cyc_q,       cyc_d;

    logic abort_req;
    logic round_end;
    logic last_round;

    // The abort request collapses to a constant zero in the default build so
    // the next-state logic below is written once for both configurations.
`ifdef AES_ROUND_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // GF(2^8) doubling used to derive the next round constant from the
    // current one; reduction polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    endfunction

    assign round_end  = (cyc_q == LAST_CYCLE);
    assign last_round = (round_idx_q == LAST_ROUND);

    // Next-state and output decode. Every output defaults low and the state
    // registers default to holding; each state only overrides what it needs.
    // The strobes to the datapath are additionally gated with rst so that a
    // reset cycle never commits a half-finished round.
    always_comb begin
        state_d     = state_q;
        round_idx_d = round_idx_q;
        rcon_d      = rcon_q;
        cyc_d       = cyc_q;
        in_ready    = 1'b0;
        load_in     = 1'b0;
        state_ld    = 1'b0;
        key_step    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = ~rst;
                load_in  = in_valid & ~rst;
                if (in_valid && !rst) begin
                    state_d     = ST_ROUND;
                    round_idx_d = 4'd1;
                    rcon_d      = RCON_INIT;
                    cyc_d       = 2'd0;
                end
            end

            ST_ROUND: begin
                busy = 1'b1;
                if (abort_req) begin
                    state_d     = ST_IDLE;
                    round_idx_d = 4'd0;
                    rcon_d      = RCON_INIT;
                    cyc_d       = 2'd0;
                end else if (round_end) begin
                    // One commit strobe per round, on the round's last cycle.
                    state_ld = ~rst;
                    key_step = ~rst;
                    cyc_d    = 2'd0;
                    if (last_round) begin
                        // round_idx stays at NUM_ROUNDS while the result is held.
                        state_d = ST_DONE;
                    end else begin
                        round_idx_d = round_idx_q + 4'd1;
                        rcon_d      = xtime(rcon_q);
                    end
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end

            ST_DONE: begin
                if (abort_req) begin
                    state_d     = ST_IDLE;
                    round_idx_d = 4'd0;
                    rcon_d      = RCON_INIT;
                    cyc_d       = 2'd0;
                end else begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        round_idx_d = 4'd0;
                        rcon_d      = RCON_INIT;
                    end
                end
            end

            default: begin
                state_d     = ST_IDLE;
                round_idx_d = 4'd0;
                rcon_d      = RCON_INIT;
                cyc_d       = 2'd0;
            end
        endcase
    end

    // MixColumns is skipped only in the final round; since round_idx is
    // constant for a whole round this stays stable across all its cycles.
    assign mix_en    = ~last_round;
    assign round_idx = round_idx_q;
    assign rcon      = rcon_q;

    // State registers with synchronous reset back to an empty IDLE controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            round_idx_q <= 4'd0;
            rcon_q      <= RCON_INIT;
            cyc_q       <= 2'd0;
        end else begin
            state_q     <= state_d;
            round_idx_q <= round_idx_d;
            rcon_q      <= rcon_d;
            cyc_q       <= cyc_d;
        end
    end

endmodule
